sync_ram_2p: RTL and testbench



---
 rtl/sync_ram_2p_pkg.sv | 26 ++
 rtl/sync_ram_2p_clear_ctrl.sv | 67 ++++++
 rtl/sync_ram_2p.sv | 182 ++++++++++++++++++
 tb/tb_sync_ram_2p.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_ram_2p_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ram_2p_pkg
//  Description : Shared definitions for the sync_ram_2p RAM.
//                - Encodings for the clear-controller states.
//                - Codes for the read-during-write modes.
//                - Helper that gives the number of write-mask lanes.
//  Revision    : 1.0  initial release
// ============================================================================
package sync_ram_2p_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } clr_state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Number of write-mask lanes: LANES = WordSize / ByteSize
    function automatic int ram_lanes(input int word_size, input int byte_size);
        return word_size / byte_size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ram_2p_clear_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ram_clear_ctrl
//  Description : Clear sequencer for sync_ram_2p. After reset it sweeps every
//                address and raises a write strobe on each one so the RAM
//                zeroes that word.
//  Ports       : i_clock      - clock
//                i_reset      - synchronous active-high reset
//                o_busy       - high while the sweep is running
//                o_clear_addr - address being cleared in this cycle
//                o_clear_we   - write strobe for the clear write
//  Revision    : 1.0  initial release
// ============================================================================
module ram_clear_ctrl
    import sync_ram_2p_pkg::*;
#(
    parameter int AddressSize  = 4,
    parameter bit ClearOnReset = 1'b1
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    output logic                   o_busy,
    output logic [AddressSize-1:0] o_clear_addr,
    output logic                   o_clear_we
);

    // The counter has one more bit than the address. Its MSB marks the end
    // of the sweep, so the address bits can never wrap back to 0.
    localparam int CNT_W = AddressSize + 1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{AddressSize{1'b0}}, 1'b1};

    clr_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= (ClearOnReset != 1'b0) ? ST_CLEAR : ST_READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + C_CNT_ONE;
            if (cnt_d[CNT_W-1]) begin
                state_d = ST_READY;
            end
        end
    end

    // Outputs. The clear write is held off during the reset cycle, so reset
    // itself never changes the memory contents.
    always_comb begin
        o_busy       = (state_q == ST_CLEAR);
        o_clear_we   = o_busy & ~i_reset;
        o_clear_addr = cnt_q[AddressSize-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/sync_ram_2p.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ram_2p
//  Description : Simple dual-port synchronous RAM on one clock.
//                - One write port with a per-lane byte mask.
//                - One read port; latency is 1 or 2 cycles.
//                - RdwMode sets read-during-write behaviour (old or new data).
//                - Optional zero-clear sweep after reset.
//  Ports       : Clock, Reset                     - clock, sync active-high reset
//                WrEn, WrAddress, WrData, WrMask  - write port
//                RdEn, RdAddress                  - read request
//                RdData, RdValid                  - read result plus valid pulse
//                Busy                             - clear sweep in progress
//                Error                            - access attempted while Busy
//  Revision    : 1.0  initial release
// ============================================================================
module sync_ram_2p
    import sync_ram_2p_pkg::*;
#(
    parameter int AddressSize  = 4,
    parameter int WordSize     = 8,
    parameter int ByteSize     = 8,
    parameter int ReadLatency  = 1,
    parameter int RdwMode      = 0,
    parameter bit ClearOnReset = 1'b1
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           WrEn,
    input  logic [AddressSize-1:0]         WrAddress,
    input  logic [WordSize-1:0]            WrData,
    input  logic [WordSize/ByteSize-1:0]   WrMask,
    input  logic                           RdEn,
    input  logic [AddressSize-1:0]         RdAddress,
    output logic [WordSize-1:0]            RdData,
    output logic                           RdValid,
    output logic                           Busy,
    output logic                           Error
);

    localparam int LANES = ram_lanes(WordSize, ByteSize);
    localparam int DEPTH = 2 ** AddressSize;

    if ((WordSize % ByteSize) != 0) begin : g_chk_word
        $error("sync_ram_2p: WordSize must be a multiple of ByteSize");
    end
    if ((ReadLatency != 1) && (ReadLatency != 2)) begin : g_chk_lat
        $error("sync_ram_2p: ReadLatency must be 1 or 2");
    end

    logic                   w_busy;
    logic [AddressSize-1:0] w_clr_addr;
    logic                   w_clr_we;

    ram_clear_ctrl #(
        .AddressSize  (AddressSize),
        .ClearOnReset (ClearOnReset)
    ) u_clear_ctrl (
        .i_clock      (Clock),
        .i_reset      (Reset),
        .o_busy       (w_busy),
        .o_clear_addr (w_clr_addr),
        .o_clear_we   (w_clr_we)
    );

    logic [WordSize-1:0]    mem_q [DEPTH];

    logic                   w_user_wr;
    logic                   w_rd_accept;
    logic                   w_wr_en;
    logic [AddressSize-1:0] w_wr_addr;
    logic [WordSize-1:0]    w_wr_data;
    logic [LANES-1:0]       w_wr_mask;
    logic [WordSize-1:0]    w_rd_word;

    // The user port is accepted only when the RAM is ready and out of reset.
    // While the sweep runs, the clear write takes over the write port.
    always_comb begin
        w_user_wr   = WrEn & ~w_busy & ~Reset;
        w_rd_accept = RdEn & ~w_busy & ~Reset;
        w_wr_en     = w_clr_we | w_user_wr;
        w_wr_addr   = w_clr_we ? w_clr_addr : WrAddress;
        w_wr_data   = w_clr_we ? '0 : WrData;
        w_wr_mask   = w_clr_we ? '1 : WrMask;
    end

    always_ff @(posedge Clock) begin
        if (w_wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (w_wr_mask[i]) begin
                    mem_q[w_wr_addr][i*ByteSize +: ByteSize] <= w_wr_data[i*ByteSize +: ByteSize];
                end
            end
        end
    end

    // The read word is chosen at the accept edge. In write-through mode,
    // lanes being written at that edge replace the stored lanes.
    always_comb begin
        w_rd_word = mem_q[RdAddress];
        if ((RdwMode == RDW_NEW) && w_user_wr && (WrAddress == RdAddress)) begin
            for (int i = 0; i < LANES; i++) begin
                if (WrMask[i]) begin
                    w_rd_word[i*ByteSize +: ByteSize] = WrData[i*ByteSize +: ByteSize];
                end
            end
        end
    end

    // Capture stage: loaded on the accept edge
    logic                cap_valid_q, cap_valid_d;
    logic [WordSize-1:0] cap_data_q,  cap_data_d;

    always_comb begin
        cap_valid_d = w_rd_accept;
        cap_data_d  = w_rd_accept ? w_rd_word : cap_data_q;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cap_valid_q <= 1'b0;
            cap_data_q  <= '0;
        end else begin
            cap_valid_q <= cap_valid_d;
            cap_data_q  <= cap_data_d;
        end
    end

    logic                w_src_valid;
    logic [WordSize-1:0] w_src_data;

    if (ReadLatency == 2) begin : g_lat2
        logic                mid_valid_q;
        logic [WordSize-1:0] mid_data_q;

        always_ff @(posedge Clock) begin
            if (Reset) begin
                mid_valid_q <= 1'b0;
                mid_data_q  <= '0;
            end else begin
                mid_valid_q <= cap_valid_q;
                mid_data_q  <= cap_data_q;
            end
        end

        assign w_src_valid = mid_valid_q;
        assign w_src_data  = mid_data_q;
    end else begin : g_lat1
        assign w_src_valid = cap_valid_q;
        assign w_src_data  = cap_data_q;
    end

    // Output register: RdData keeps its last value between valid pulses
    logic                rd_valid_q, rd_valid_d;
    logic [WordSize-1:0] rd_data_q,  rd_data_d;
    logic                error_q,    error_d;

    always_comb begin
        rd_valid_d = w_src_valid;
        rd_data_d  = w_src_valid ? w_src_data : rd_data_q;
        error_d    = w_busy & (WrEn | RdEn);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            error_q    <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            error_q    <= error_d;
        end
    end

    assign RdData  = rd_data_q;
    assign RdValid = rd_valid_q;
    assign Busy    = w_busy;
    assign Error   = error_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_ram_2p.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_ram_2p
//  Description : Self-checking bench for sync_ram_2p. Two instances share the
//                same stimulus:
//                  dut_a: ReadLatency 1, RdwMode 0 (returns old data)
//                  dut_b: ReadLatency 2, RdwMode 1 (returns new data)
//                Both use 16 addresses, 16-bit words and 8-bit lanes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sync_ram_2p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, we, re;
    logic [3:0]  wa, ra;
    logic [15:0] wd;
    logic [1:0]  wm;

    logic [15:0] data_a, data_b;
    logic        valid_a, valid_b, busy_a, busy_b, err_a, err_b;

    sync_ram_2p #(.AddressSize(4), .WordSize(16), .ByteSize(8), .ReadLatency(1),
                  .RdwMode(0), .ClearOnReset(1'b1)) dut_a (
        .Clock(clk), .Reset(rst), .WrEn(we), .WrAddress(wa), .WrData(wd), .WrMask(wm),
        .RdEn(re), .RdAddress(ra), .RdData(data_a), .RdValid(valid_a),
        .Busy(busy_a), .Error(err_a));

    sync_ram_2p #(.AddressSize(4), .WordSize(16), .ByteSize(8), .ReadLatency(2),
                  .RdwMode(1), .ClearOnReset(1'b1)) dut_b (
        .Clock(clk), .Reset(rst), .WrEn(we), .WrAddress(wa), .WrData(wd), .WrMask(wm),
        .RdEn(re), .RdAddress(ra), .RdData(data_b), .RdValid(valid_b),
        .Busy(busy_b), .Error(err_b));

    int n_vec = 0;
    int n_mis = 0;

    // ---------------- reference model ----------------
    typedef struct { int due; logic [15:0] data; } rd_t;
    rd_t         qa[$];
    rd_t         qb[$];
    logic [15:0] m_mem [16];
    int          m_busy_left = 0;
    logic [15:0] m_data [2];
    logic        m_valid [2];
    logic        m_err = 1'b0;
    int          cyc = 0;

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n,
                                          input logic [1:0] m);
        logic [15:0] r;
        r = o;
        if (m[0]) r[7:0]  = n[7:0];
        if (m[1]) r[15:8] = n[15:8];
        return r;
    endfunction

    task automatic model_step();
        logic [15:0] old_w;
        cyc++;
        if (rst) begin
            m_busy_left = 16;
            qa.delete();
            qb.delete();
            m_data[0] = '0; m_data[1] = '0;
            m_valid[0] = 1'b0; m_valid[1] = 1'b0;
            m_err = 1'b0;
        end else begin
            m_err = (m_busy_left > 0) && (we || re);
            if (m_busy_left > 0) begin
                m_mem[16 - m_busy_left] = '0;
                m_busy_left--;
            end else begin
                if (re) begin
                    old_w = m_mem[ra];
                    qa.push_back('{cyc + 1, old_w});
                    qb.push_back('{cyc + 2, (we && wa == ra) ? merge(old_w, wd, wm) : old_w});
                end
                if (we) m_mem[wa] = merge(m_mem[wa], wd, wm);
            end
            m_valid[0] = 1'b0;
            if (qa.size() > 0 && qa[0].due == cyc) begin
                m_valid[0] = 1'b1; m_data[0] = qa[0].data; void'(qa.pop_front());
            end
            m_valid[1] = 1'b0;
            if (qb.size() > 0 && qb[0].due == cyc) begin
                m_valid[1] = 1'b1; m_data[1] = qb[0].data; void'(qb.pop_front());
            end
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle on the falling edge, step the model at the rising edge,
    // then compare every output 1 time unit later.
    task automatic cycle(input logic r, input logic w, input logic [3:0] a,
                         input logic [15:0] d, input logic [1:0] m,
                         input logic e, input logic [3:0] b);
        @(negedge clk);
        rst = r; we = w; wa = a; wd = d; wm = m; re = e; ra = b;
        @(posedge clk);
        model_step();
        #1;
        chk("busy_a",  {15'b0, busy_a},  {15'b0, m_busy_left > 0});
        chk("busy_b",  {15'b0, busy_b},  {15'b0, m_busy_left > 0});
        chk("err_a",   {15'b0, err_a},   {15'b0, m_err});
        chk("err_b",   {15'b0, err_b},   {15'b0, m_err});
        chk("valid_a", {15'b0, valid_a}, {15'b0, m_valid[0]});
        chk("valid_b", {15'b0, valid_b}, {15'b0, m_valid[1]});
        chk("data_a",  data_a, m_data[0]);
        chk("data_b",  data_b, m_data[1]);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [1:0]  wm;
        logic        re;
        logic [3:0]  ra;
        logic        chk_rd;
        logic [15:0] exp_old;   // expected result with RdwMode 0
        logic [15:0] exp_new;   // expected result with RdwMode 1
    } vec_t;

    vec_t tbl [16];

    task automatic fill_table();
        tbl[0]  = '{1'b1, 4'd3,  16'h00A5, 2'b11, 1'b0, 4'd0,  1'b0, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd3,  1'b1, 16'h00A5, 16'h00A5};
        tbl[2]  = '{1'b1, 4'd5,  16'h1234, 2'b11, 1'b0, 4'd0,  1'b0, 16'h0000, 16'h0000};
        tbl[3]  = '{1'b1, 4'd5,  16'hABCD, 2'b01, 1'b0, 4'd0,  1'b0, 16'h0000, 16'h0000};
        tbl[4]  = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd5,  1'b1, 16'h12CD, 16'h12CD};
        tbl[5]  = '{1'b1, 4'd7,  16'h0011, 2'b11, 1'b0, 4'd0,  1'b0, 16'h0000, 16'h0000};
        tbl[6]  = '{1'b1, 4'd7,  16'h0022, 2'b11, 1'b1, 4'd7,  1'b1, 16'h0011, 16'h0022};
        tbl[7]  = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd7,  1'b1, 16'h0022, 16'h0022};
        tbl[8]  = '{1'b1, 4'd9,  16'hBEEF, 2'b00, 1'b0, 4'd0,  1'b0, 16'h0000, 16'h0000};
        tbl[9]  = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd9,  1'b1, 16'h0000, 16'h0000};
        tbl[10] = '{1'b1, 4'd9,  16'hBEEF, 2'b10, 1'b0, 4'd0,  1'b0, 16'h0000, 16'h0000};
        tbl[11] = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd9,  1'b1, 16'hBE00, 16'hBE00};
        tbl[12] = '{1'b1, 4'd9,  16'h1234, 2'b01, 1'b1, 4'd9,  1'b1, 16'hBE00, 16'hBE34};
        tbl[13] = '{1'b1, 4'd10, 16'h5555, 2'b11, 1'b1, 4'd3,  1'b1, 16'h00A5, 16'h00A5};
        tbl[14] = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd10, 1'b1, 16'h5555, 16'h5555};
        tbl[15] = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd15, 1'b1, 16'h0000, 16'h0000};
    endtask

    task automatic wait_clear(input int budget);
        for (int k = 0; k < budget && busy_a; k++) idle();
        chk("clear_done", {15'b0, busy_a}, 16'h0);
    endtask

    initial begin
        int bcount;
        int vcount;
        logic got_a, got_b, vseen;

        rst = 1'b1; we = 1'b0; re = 1'b0; wa = '0; ra = '0; wd = '0; wm = '0;
        m_data[0] = '0; m_data[1] = '0; m_valid[0] = 1'b0; m_valid[1] = 1'b0;
        for (int i = 0; i < 16; i++) m_mem[i] = '0;

        // Clear sweep: Busy must stay high for exactly 16 cycles.
        cycle(1'b1, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);
        cycle(1'b1, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);
        bcount = busy_a ? 1 : 0;
        for (int k = 0; k < 40 && busy_a; k++) begin
            idle();
            if (busy_a) bcount++;
        end
        chk("busy_cycles", 16'(bcount), 16'd16);

        // Read back all 16 words at full throughput; each returns zero.
        vcount = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(i));
            if (valid_b) vcount++;
        end
        for (int k = 0; k < 3; k++) begin
            idle();
            if (valid_b) vcount++;
        end
        chk("sweep_read_pulses", 16'(vcount), 16'd16);

        // Table of directed vectors
        fill_table();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].wm, tbl[i].re, tbl[i].ra);
            if (tbl[i].chk_rd) begin
                got_a = 1'b0; got_b = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    idle();
                    if (!got_a && valid_a) begin got_a = 1'b1; chk("tbl_a", data_a, tbl[i].exp_old); end
                    if (!got_b && valid_b) begin got_b = 1'b1; chk("tbl_b", data_b, tbl[i].exp_new); end
                end
                chk("tbl_a_seen", {15'b0, got_a}, 16'h1);
                chk("tbl_b_seen", {15'b0, got_b}, 16'h1);
            end
        end

        // Back-to-back reads of 3, 4, 3 give three consecutive valid pulses.
        cycle(1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3);
        cycle(1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd4);
        chk("b2b_a0", data_a, 16'h00A5);
        cycle(1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3);
        chk("b2b_a1", data_a, 16'h0000);
        chk("b2b_b0", data_b, 16'h00A5);
        idle();
        chk("b2b_a2", data_a, 16'h00A5);
        chk("b2b_b1", data_b, 16'h0000);
        idle();
        chk("b2b_b2", data_b, 16'h00A5);

        // Access while Busy: the access is rejected and Error pulses once.
        cycle(1'b1, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);
        cycle(1'b0, 1'b1, 4'd2, 16'h00FF, 2'b11, 1'b0, 4'd0);
        chk("busy_err_wr", {15'b0, err_a}, 16'h1);
        cycle(1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd2);
        chk("busy_err_rd", {15'b0, err_b}, 16'h1);
        idle();
        chk("busy_err_pulse", {15'b0, err_a}, 16'h0);
        chk("busy_no_valid", {15'b0, valid_a | valid_b}, 16'h0);
        wait_clear(40);
        cycle(1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd2);
        idle();
        idle();
        chk("busy_addr2_a", data_a, 16'h0000);
        chk("busy_addr2_b", data_b, 16'h0000);

        // A read in flight is flushed by reset; then reset again at
        // sweep address 9, which restarts a full 16-cycle sweep.
        cycle(1'b0, 1'b1, 4'd4, 16'h7777, 2'b11, 1'b0, 4'd0);
        cycle(1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd4);
        vseen = 1'b0;
        cycle(1'b1, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);
        vseen = vseen | valid_a | valid_b;
        for (int k = 0; k < 9; k++) begin
            idle();
            vseen = vseen | valid_a | valid_b;
        end
        cycle(1'b1, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);
        bcount = busy_a ? 1 : 0;
        for (int k = 0; k < 40 && busy_a; k++) begin
            idle();
            vseen = vseen | valid_a | valid_b;
            if (busy_a) bcount++;
        end
        chk("restart_busy_cycles", 16'(bcount), 16'd16);
        idle();
        idle();
        vseen = vseen | valid_a | valid_b;
        chk("flush_no_valid", {15'b0, vseen}, 16'h0);

        // Random traffic with occasional resets, checked against the model
        for (int n = 0; n < 600; n++) begin
            logic [3:0] a_w, a_r;
            a_w = 4'($urandom_range(0, 15));
            a_r = ($urandom_range(0, 1) == 0) ? a_w : 4'($urandom_range(0, 15));
            cycle(($urandom_range(0, 149) == 0), 1'($urandom), a_w, 16'($urandom),
                  2'($urandom), 1'($urandom), a_r);
        end
        idle();
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
